stack_seq: RTL and testbench

//  Stack-machine sequencer: initiator side of the Stack PUSH/POP/TOS interface.

---
 rtl/stack_seq.sv | 156 +++++++++++++++
 tb/tb_stack_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// Stack-machine sequencer: accepts postfix instructions and drives Stack PUSH/POP/TOS strobes.
// Optional STACK_SEQ_MUL_EN enables opcode 111 as MUL; without it 111 is illegal.
module stack_seq #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_instr_valid,
  output logic          o_instr_ready,
  input  logic [2:0]    i_instr_op,
  input  logic [W-1:0]  i_instr_imm,
  output logic [W-1:0]  o_stk_out,
  input  logic [W-1:0]  i_stk_in,
  output logic          o_stk_push,
  output logic          o_stk_pop,
  output logic          o_stk_tos,
  output logic [W-1:0]  o_result,
  output logic [DW-1:0] o_depth,
  output logic          o_err
);

  localparam logic [2:0] OP_DROP  = 3'b000;
  localparam logic [2:0] OP_PUSHI = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_DUP   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;
  localparam logic [DW-1:0] LP_DEPTH = DW'(DEPTH);
  localparam logic [DW-1:0] LP_ONE   = DW'(1);
  localparam logic [DW-1:0] LP_TWO   = DW'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_TOS_A, S_RD_A, S_TOS_B, S_RD_B, S_PUSH_R
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [2:0]     r_op;
  logic [W-1:0]   r_imm;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_result;
  logic [DW-1:0]  r_depth;
  logic           r_err;
  logic           w_accept;
  logic           w_legal;
  logic [W-1:0]   w_val;
`ifdef STACK_SEQ_MUL_EN
  logic [2*W-1:0] w_prod;
  assign w_prod = r_a * r_b;
`endif

  assign w_accept = i_instr_valid & o_instr_ready;

  // Operand-availability checks are made against the depth seen at acceptance.
  always_comb begin
    w_legal = 1'b0;
    case (i_instr_op)
      OP_DROP:  w_legal = (r_depth >= LP_ONE);
      OP_PUSHI: w_legal = (r_depth < LP_DEPTH);
      OP_DUP:   w_legal = (r_depth >= LP_ONE) && (r_depth < LP_DEPTH);
`ifdef STACK_SEQ_MUL_EN
      OP_MUL:   w_legal = (r_depth >= LP_TWO);
`else
      OP_MUL:   w_legal = 1'b0;
`endif
      default:  w_legal = (r_depth >= LP_TWO);
    endcase
  end

  always_comb begin
    w_val = '0;
    case (r_op)
      OP_PUSHI: w_val = r_imm;
      OP_ADD:   w_val = r_b + r_a;
      OP_SUB:   w_val = r_b - r_a;
      OP_AND:   w_val = r_b & r_a;
      OP_OR:    w_val = r_b | r_a;
      OP_DUP:   w_val = r_a;
`ifdef STACK_SEQ_MUL_EN
      OP_MUL:   w_val = w_prod[W-1:0];
`endif
      default:  w_val = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_legal) begin
          if (i_instr_op == OP_PUSHI)     w_next = S_PUSH_R;
          else if (i_instr_op == OP_DROP) w_next = S_RD_A;
          else                            w_next = S_TOS_A;
        end
      end
      S_TOS_A:  w_next = S_RD_A;
      S_RD_A: begin
        if (r_op == OP_DROP)     w_next = S_IDLE;
        else if (r_op == OP_DUP) w_next = S_PUSH_R;
        else                     w_next = S_TOS_B;
      end
      S_TOS_B:  w_next = S_RD_B;
      S_RD_B:   w_next = S_PUSH_R;
      S_PUSH_R: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // DROP pops without reading, so TOS stays low in its RD_A.
  always_comb begin
    o_instr_ready = (r_state == S_IDLE);
    o_stk_tos     = (r_state == S_TOS_A) || (r_state == S_TOS_B) || (r_state == S_RD_B) ||
                    ((r_state == S_RD_A) && (r_op != OP_DROP));
    o_stk_pop     = (r_state == S_RD_B) || ((r_state == S_RD_A) && (r_op != OP_DUP));
    o_stk_push    = (r_state == S_PUSH_R);
    o_stk_out     = (r_state == S_PUSH_R) ? w_val : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_depth  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= i_instr_op;
        r_imm <= i_instr_imm;
        if (!w_legal) r_err <= 1'b1;
      end
      if ((r_state == S_RD_A) && (r_op != OP_DROP)) r_a <= i_stk_in;
      if (r_state == S_RD_B)                        r_b <= i_stk_in;
      if (o_stk_push)     r_result <= w_val;
      if (o_stk_push)     r_depth  <= r_depth + LP_ONE;
      else if (o_stk_pop) r_depth  <= r_depth - LP_ONE;
    end
  end

  assign o_result = r_result;
  assign o_depth  = r_depth;
  assign o_err    = r_err;

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq with a behavioural Stack attached to the strobes.
module tb_stack_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = 3'd0;
  logic [7:0] instr_imm = 8'd0;
  logic [7:0] stk_out, stk_in, result;
  logic       stk_push, stk_pop, stk_tos, err;
  logic [3:0] depth;

  typedef struct { logic [7:0] val; int cyc; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] mem [0:15];
  int   sp = 0;

  stack_seq #(.W(8), .DEPTH(8), .DW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr_op(instr_op), .i_instr_imm(instr_imm), .o_stk_out(stk_out), .i_stk_in(stk_in),
    .o_stk_push(stk_push), .o_stk_pop(stk_pop), .o_stk_tos(stk_tos),
    .o_result(result), .o_depth(depth), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural Stack: top word is always visible on stk_in.
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (stk_push && sp < 16) begin mem[sp] <= stk_out; sp <= sp + 1; end
    else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_in = (sp > 0) ? mem[sp-1] : 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && stk_push) begin
      chk("strobe_exclusive", int'(stk_pop | stk_tos), 0);
      if (sb.size() == 0) chk("unexpected_push", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("push_value", int'(stk_out), int'(e.val));
        chk("push_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; sb.delete();
    @(negedge clk); rst = 1'b0;
  endtask

  // off = cycles from acceptance edge to the expected push (0 = no push).
  task automatic issue(input logic [2:0] op, input logic [7:0] imm, input bit legal,
                       input logic [7:0] exp_val, input int off, input bit wait_done);
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    if (!instr_ready) begin chk("accept_timeout", 0, 1); return; end
    instr_valid = 1'b1; instr_op = op; instr_imm = imm;
    if (legal && off > 0) sb.push_back('{exp_val, cyc + off});
    @(posedge clk); #1 instr_valid = 1'b0;
    if (!legal) begin
      @(negedge clk);
      chk("reject_no_strobes", int'({stk_push, stk_pop, stk_tos}), 0);
      chk("reject_stays_idle", int'(instr_ready), 1);
    end else if (wait_done) begin
      n = 0;
      @(negedge clk);
      while (!instr_ready && n < 50) begin @(negedge clk); n++; end
      if (!instr_ready) chk("done_timeout", 0, 1);
    end
  endtask

  task automatic chk_state(input string tag, input int exp_depth, input int exp_err, input int exp_res);
    @(negedge clk);
    chk({tag, "_depth"}, int'(depth), exp_depth);
    chk({tag, "_err"}, int'(err), exp_err);
    chk({tag, "_result"}, int'(result), exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_strobes", int'({stk_push, stk_pop, stk_tos}), 0);
    chk("rst_stk_out", int'(stk_out), 0);

    // SUB = b - a, push five cycles after acceptance
    issue(3'b001, 8'h3C, 1, 8'h3C, 1, 1);
    issue(3'b001, 8'h30, 1, 8'h30, 1, 1);
    issue(3'b011, 8'h00, 1, 8'h0C, 5, 1);
    chk_state("sub", 1, 0, 8'h0C);

    do_reset();
    issue(3'b001, 8'hF0, 1, 8'hF0, 1, 1);
    issue(3'b001, 8'h20, 1, 8'h20, 1, 1);
    issue(3'b010, 8'h00, 1, 8'h10, 5, 1);
    chk_state("add_wrap", 1, 0, 8'h10);

    do_reset();
    issue(3'b001, 8'hC3, 1, 8'hC3, 1, 1);
    issue(3'b001, 8'h0F, 1, 8'h0F, 1, 1);
    issue(3'b100, 8'h00, 1, 8'h03, 5, 1);
    issue(3'b001, 8'h50, 1, 8'h50, 1, 1);
    issue(3'b101, 8'h00, 1, 8'h53, 5, 1);
    chk_state("and_or", 1, 0, 8'h53);
    issue(3'b010, 8'h00, 0, 8'h00, 0, 1);
    chk_state("binary_underflow", 1, 1, 8'h53);

    // Full stack: PUSHI and DUP rejected, DROP still works, err stays sticky
    do_reset();
    for (int i = 1; i <= 8; i++) issue(3'b001, 8'(i), 1, 8'(i), 1, 1);
    chk_state("full", 8, 0, 8);
    issue(3'b001, 8'hAA, 0, 8'h00, 0, 1);
    chk_state("overflow", 8, 1, 8);
    issue(3'b110, 8'h00, 0, 8'h00, 0, 1);
    issue(3'b000, 8'h00, 1, 8'h00, 0, 1);
    chk_state("drop_after_err", 7, 1, 8);
    issue(3'b110, 8'h00, 1, 8'h07, 3, 1);
    chk_state("dup_to_full", 8, 1, 7);

    do_reset();
    issue(3'b000, 8'h00, 0, 8'h00, 0, 1);
    chk_state("drop_empty", 0, 1, 0);
    issue(3'b001, 8'h05, 1, 8'h05, 1, 1);
    issue(3'b110, 8'h00, 1, 8'h05, 3, 1);
    chk_state("dup", 2, 1, 5);
    issue(3'b010, 8'h00, 1, 8'h0A, 5, 1);
    chk_state("dup_add", 1, 1, 8'h0A);

    do_reset();
    issue(3'b001, 8'h03, 1, 8'h03, 1, 1);
    issue(3'b001, 8'h04, 1, 8'h04, 1, 1);
`ifdef STACK_SEQ_MUL_EN
    issue(3'b111, 8'h00, 1, 8'd12, 5, 1);
    chk_state("mul", 1, 0, 12);
`else
    issue(3'b111, 8'h00, 0, 8'h00, 0, 1);
    chk_state("op111_illegal", 2, 1, 4);
`endif

    // Reset during TOS_B aborts the ADD
    do_reset();
    issue(3'b001, 8'h01, 1, 8'h01, 1, 1);
    issue(3'b001, 8'h02, 1, 8'h02, 1, 1);
    issue(3'b010, 8'h00, 1, 8'h03, 5, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("tos_b_strobes", int'({stk_push, stk_pop, stk_tos}), 1);
    rst = 1'b1; sb.delete();
    @(negedge clk);
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_depth", int'(depth), 0);
    chk("abort_strobes", int'({stk_push, stk_pop, stk_tos}), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_push_later", int'(result), 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
